// File: rtl/vote_pkg.sv
// Shared definitions for the plurality vote datapath: session states,
// default geometry and small helper functions.
package vote_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_TALLY = 2'd2,
        ST_DONE  = 2'd3
    } vote_state_e;

    localparam int DEF_N_VOTERS = 5;
    localparam int DEF_N_CAND   = 3;

    function automatic int vote_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // True when exactly one bit of a zero-extended ballot is set.
    function automatic logic vote_onehot(input logic [31:0] value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/vote_resolve.sv
// Picks the candidate with the largest count; ties go to the highest index.
// All-zero counts produce no winner and flag no_quorum.
module vote_resolve #(
    parameter int N_CAND = 3,
    parameter int CW     = 3
) (
    input  logic [N_CAND*CW-1:0] counts,
    output logic [N_CAND-1:0]    result,
    output logic                 no_quorum
);

    logic [CW-1:0] best_cnt;
    int            best_idx;

    always_comb begin
        best_cnt = '0;
        best_idx = 0;
        // ">=" lets a later (higher) index take over on equal counts.
        for (int c = 0; c < N_CAND; c++) begin
            if (counts[c*CW +: CW] >= best_cnt) begin
                best_cnt = counts[c*CW +: CW];
                best_idx = c;
            end
        end
        no_quorum = (best_cnt == '0);
        for (int c = 0; c < N_CAND; c++) begin
            result[c] = !no_quorum && (c == best_idx);
        end
    end

endmodule

// File: rtl/vote_session_ctrl.sv
// One voting session: open window, collect one-hot ballots per voter,
// close, tally one stored ballot per cycle, then publish the winner.
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int N_VOTERS = DEF_N_VOTERS,
    parameter int N_CAND   = DEF_N_CAND,
    parameter int TIMEOUT  = 255,
    parameter int CW       = vote_clog2(N_VOTERS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   close,
    input  logic [N_VOTERS-1:0]    ballot_valid,
    input  logic [N_VOTERS*N_CAND-1:0] ballot,
    output logic [N_VOTERS-1:0]    ballot_ack,
    output logic [N_VOTERS-1:0]    ballot_nack,
    output logic [N_VOTERS-1:0]    voted,
    output logic                   busy,
    output logic                   result_valid,
    output logic [N_CAND-1:0]      result,
    output logic                   no_quorum,
    output logic [N_CAND*CW-1:0]   counts
);

    localparam int TW = (vote_clog2(TIMEOUT + 1) < 1) ? 1 : vote_clog2(TIMEOUT + 1);

    vote_state_e           state_q, state_d;
    logic [N_CAND-1:0]     ballots_q [N_VOTERS];
    logic [N_CAND-1:0]     ballots_d [N_VOTERS];
    logic [N_VOTERS-1:0]   voted_q, voted_d;
    logic [N_VOTERS-1:0]   ack_q, ack_d;
    logic [N_VOTERS-1:0]   nack_q, nack_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [CW-1:0]         idx_q, idx_d;
    logic [N_CAND*CW-1:0]  counts_q, counts_d;
    logic [N_CAND-1:0]     result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic                  no_quorum_q, no_quorum_d;
    logic [N_CAND-1:0]     res_w;
    logic                  nq_w;

    vote_resolve #(
        .N_CAND (N_CAND),
        .CW     (CW)
    ) u_resolve (
        .counts    (counts_q),
        .result    (res_w),
        .no_quorum (nq_w)
    );

    always_comb begin
        state_d        = state_q;
        ballots_d      = ballots_q;
        voted_d        = voted_q;
        ack_d          = '0;
        nack_d         = ballot_valid;
        timer_d        = timer_q;
        idx_d          = idx_q;
        counts_d       = counts_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        no_quorum_d    = no_quorum_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    for (int i = 0; i < N_VOTERS; i++) begin
                        ballots_d[i] = '0;
                    end
                    voted_d        = '0;
                    counts_d       = '0;
                    result_d       = '0;
                    result_valid_d = 1'b0;
                    no_quorum_d    = 1'b0;
                    timer_d        = '0;
                    state_d        = ST_OPEN;
                end
            end
            ST_OPEN: begin
                nack_d = '0;
                for (int i = 0; i < N_VOTERS; i++) begin
                    if (ballot_valid[i]) begin
                        if (vote_onehot(32'(ballot[i*N_CAND +: N_CAND])) && !voted_q[i]) begin
                            ballots_d[i] = ballot[i*N_CAND +: N_CAND];
                            voted_d[i]   = 1'b1;
                            ack_d[i]     = 1'b1;
                        end else begin
                            nack_d[i] = 1'b1;
                        end
                    end
                end
                timer_d = timer_q + TW'(1);
                // Closing decision sees this cycle's accepts, so a full house ends early.
                if (close || (&voted_d) || (timer_q == TW'(TIMEOUT - 1))) begin
                    idx_d   = '0;
                    state_d = ST_TALLY;
                end
            end
            ST_TALLY: begin
                if (idx_q < CW'(N_VOTERS)) begin
                    for (int c = 0; c < N_CAND; c++) begin
                        counts_d[c*CW +: CW] = counts_q[c*CW +: CW] + CW'(ballots_q[idx_q][c]);
                    end
                    idx_d = idx_q + CW'(1);
                end else begin
                    result_d       = res_w;
                    no_quorum_d    = nq_w;
                    result_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            for (int i = 0; i < N_VOTERS; i++) begin
                ballots_q[i] <= '0;
            end
            voted_q        <= '0;
            ack_q          <= '0;
            nack_q         <= '0;
            timer_q        <= '0;
            idx_q          <= '0;
            counts_q       <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            no_quorum_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ballots_q      <= ballots_d;
            voted_q        <= voted_d;
            ack_q          <= ack_d;
            nack_q         <= nack_d;
            timer_q        <= timer_d;
            idx_q          <= idx_d;
            counts_q       <= counts_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            no_quorum_q    <= no_quorum_d;
        end
    end

    assign ballot_ack   = ack_q;
    assign ballot_nack  = nack_q;
    assign voted        = voted_q;
    assign busy         = (state_q == ST_OPEN) || (state_q == ST_TALLY);
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign no_quorum    = no_quorum_q;
    assign counts       = counts_q;

endmodule
